mem_stage: RTL and testbench

Memory-access stage of the multi-cycle core. It sits directly downstream of the ALU stage and consumes that stage's memory-bound results: effective address, store data, destination register, load/store flags and access size. It performs one load or store per instruction over a request/grant/response data-memory port, stalls the ALU stage while the access is outstanding, and hands load results to the writeback stage.

---
 rtl/params_pkg.sv | 22 ++
 rtl/mem_data_align.sv | 41 ++++
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared core parameters and types used by the pipeline stages.
package params_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int REGISTER_WIDTH = 5;

  // Memory access granularity.
  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } access_size_t;

  // Memory stage sequencing: request issue, response wait, writeback pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_data_align.sv
// Byte-lane steering between the core and a 32-bit data memory word.
// Produces byte enables and replicated store data, and extracts the
// (sign-extended) load value from a read word. Purely combinational.
module mem_data_align
  import params_pkg::*;
#(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
  input  access_size_t          size,
  input  logic [1:0]            lane,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0] lane_byte;

  // Select the addressed byte out of the read word.
  always_comb begin
    lane_byte = rdata[{lane, 3'b000} +: 8];
  end

  // Steer store data/enables and format the load result by access size.
  always_comb begin
    be        = 4'b0000;
    wdata     = '0;
    load_data = '0;
    if (size == WORD) begin
      be        = 4'b1111;
      wdata     = rs2;
      load_data = rdata;
    end else begin
      be        = 4'b0001 << lane;
      wdata     = {(DATA_WIDTH/8){rs2[7:0]}};
      load_data = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one load or store per instruction over a
// req/gnt/rvalid data-memory port, stalls the ALU stage while busy and
// hands the result to writeback with a one-cycle valid pulse.
module mem_stage
  import params_pkg::*;
#(
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // From the ALU stage
  input  logic                      mem_valid_i,
  input  logic                      mem_is_load_i,
  input  logic                      mem_is_store_i,
  input  logic                      mem_reg_wr_en_i,
  input  access_size_t              mem_access_size_i,
  input  logic [DATA_WIDTH-1:0]     mem_alu_result_i,
  input  logic [DATA_WIDTH-1:0]     mem_rs2_data_i,
  input  logic [REGISTER_WIDTH-1:0] mem_wr_reg_i,
  output logic                      mem_stall_o,
  // Data-memory port
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [3:0]                dmem_be_o,
  output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  // To writeback
  output logic                      wb_valid_o,
  output logic                      wb_reg_wr_en_o,
  output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      misaligned_o
`ifndef SYNTHESIS
  ,
  input  logic [ADDR_WIDTH-1:0]     debug_pc_i,
  output logic [ADDR_WIDTH-1:0]     debug_wb_pc_o
`endif
);

  mem_state_t state_reg, state_next;

  // Request register: everything needed to finish the access once the
  // ALU stage has moved on.
  logic [ADDR_WIDTH-1:0]     req_addr_reg;
  access_size_t              req_size_reg;
  logic                      req_load_reg;
  logic                      req_store_reg;
  logic                      req_wr_en_reg;
  logic [REGISTER_WIDTH-1:0] req_rd_reg;
  logic [DATA_WIDTH-1:0]     req_rs2_reg;

  // Writeback register: holds the last completed result.
  logic                      wb_reg_wr_en_reg;
  logic [REGISTER_WIDTH-1:0] wb_wr_reg_reg;
  logic [DATA_WIDTH-1:0]     wb_data_reg;

  logic [3:0]            align_be;
  logic [DATA_WIDTH-1:0] align_wdata;
  logic [DATA_WIDTH-1:0] align_load;

  logic capture;
  logic resp_take;

  // A new instruction may enter whenever no access is outstanding.
  assign capture   = mem_valid_i && ((state_reg == IDLE) || (state_reg == RESP));
  // Responses only count while an access is actually waiting for one.
  assign resp_take = (state_reg == WAIT) && dmem_rvalid_i;

  mem_data_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .size      (req_size_reg),
    .lane      (req_addr_reg[1:0]),
    .rs2       (req_rs2_reg),
    .rdata     (dmem_rdata_i),
    .be        (align_be),
    .wdata     (align_wdata),
    .load_data (align_load)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = mem_valid_i ? REQ : IDLE;
      REQ:     state_next = dmem_gnt_i ? WAIT : REQ;
      WAIT:    state_next = dmem_rvalid_i ? RESP : WAIT;
      RESP:    state_next = mem_valid_i ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state; request fields are zero outside REQ so
  // the bus is quiet whenever no request is being offered.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_be_o    = 4'b0000;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    mem_stall_o  = 1'b0;
    wb_valid_o   = 1'b0;
    misaligned_o = 1'b0;
    case (state_reg)
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = req_store_reg;
        dmem_be_o    = align_be;
        dmem_addr_o  = {req_addr_reg[ADDR_WIDTH-1:2], 2'b00};
        dmem_wdata_o = align_wdata;
        mem_stall_o  = 1'b1;
      end
      WAIT: begin
        mem_stall_o  = 1'b1;
      end
      RESP: begin
        wb_valid_o   = 1'b1;
        misaligned_o = (req_size_reg == WORD) && (req_addr_reg[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  // Capture the incoming instruction into the request register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr_reg  <= '0;
      req_size_reg  <= BYTE;
      req_load_reg  <= 1'b0;
      req_store_reg <= 1'b0;
      req_wr_en_reg <= 1'b0;
      req_rd_reg    <= '0;
      req_rs2_reg   <= '0;
    end else if (capture) begin
      req_addr_reg  <= mem_alu_result_i[ADDR_WIDTH-1:0];
      req_size_reg  <= mem_access_size_i;
      req_load_reg  <= mem_is_load_i;
      req_store_reg <= mem_is_store_i;
      req_wr_en_reg <= mem_reg_wr_en_i;
      req_rd_reg    <= mem_wr_reg_i;
      req_rs2_reg   <= mem_rs2_data_i;
    end
  end

  // Latch the formatted result when the response arrives; stores never
  // write the register file and report zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_reg_wr_en_reg <= 1'b0;
      wb_wr_reg_reg    <= '0;
      wb_data_reg      <= '0;
    end else if (resp_take) begin
      wb_reg_wr_en_reg <= req_load_reg && req_wr_en_reg;
      wb_wr_reg_reg    <= req_rd_reg;
      wb_data_reg      <= req_load_reg ? align_load : '0;
    end
  end

  assign wb_reg_wr_en_o = wb_reg_wr_en_reg;
  assign wb_wr_reg_o    = wb_wr_reg_reg;
  assign wb_data_o      = wb_data_reg;

`ifndef SYNTHESIS
  logic [ADDR_WIDTH-1:0] req_pc_reg;
  logic [ADDR_WIDTH-1:0] wb_pc_reg;

  // Carry the instruction PC alongside the access for trace tooling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_pc_reg <= '0;
      wb_pc_reg  <= '0;
    end else begin
      if (capture)   req_pc_reg <= debug_pc_i;
      if (resp_take) wb_pc_reg  <= req_pc_reg;
    end
  end

  assign debug_wb_pc_o = wb_pc_reg;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases with literal
// expectations followed by randomized traffic against a transaction model.
module tb_mem_stage;
  import params_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         mem_valid, mem_is_load, mem_is_store, mem_reg_wr_en;
  access_size_t mem_access_size;
  logic [31:0]  mem_alu_result, mem_rs2_data;
  logic [4:0]   mem_wr_reg;
  logic         mem_stall;
  logic         dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]   dmem_be;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic         wb_valid, wb_reg_wr_en, misaligned;
  logic [4:0]   wb_wr_reg;
  logic [31:0]  wb_data;
  logic [31:0]  debug_pc, debug_wb_pc;

  mem_stage dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .mem_valid_i       (mem_valid),
    .mem_is_load_i     (mem_is_load),
    .mem_is_store_i    (mem_is_store),
    .mem_reg_wr_en_i   (mem_reg_wr_en),
    .mem_access_size_i (mem_access_size),
    .mem_alu_result_i  (mem_alu_result),
    .mem_rs2_data_i    (mem_rs2_data),
    .mem_wr_reg_i      (mem_wr_reg),
    .mem_stall_o       (mem_stall),
    .dmem_req_o        (dmem_req),
    .dmem_we_o         (dmem_we),
    .dmem_be_o         (dmem_be),
    .dmem_addr_o       (dmem_addr),
    .dmem_wdata_o      (dmem_wdata),
    .dmem_gnt_i        (dmem_gnt),
    .dmem_rvalid_i     (dmem_rvalid),
    .dmem_rdata_i      (dmem_rdata),
    .wb_valid_o        (wb_valid),
    .wb_reg_wr_en_o    (wb_reg_wr_en),
    .wb_wr_reg_o       (wb_wr_reg),
    .wb_data_o         (wb_data),
    .misaligned_o      (misaligned)
`ifndef SYNTHESIS
    ,
    .debug_pc_i        (debug_pc),
    .debug_wb_pc_o     (debug_wb_pc)
`endif
  );

  typedef struct {
    logic        is_load;
    logic        word;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wr_en;
    logic [31:0] pc;
  } txn_t;

  txn_t exp_q[$];     // accepted, not yet written back
  txn_t rsp_q[$];     // accepted, not yet answered by the memory
  int   rv_cyc_q[$];  // cycle of each response
  int   wb_hist[$];   // cycles of writeback pulses

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- transaction model ----------------
  function automatic logic [31:0] m_addr(input txn_t t);
    return t.addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [3:0] m_be(input txn_t t);
    int lane = int'(t.addr % 4);
    if (t.word) return 4'hF;
    case (lane)
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input txn_t t);
    if (t.word) return t.rs2;
    return {24'd0, t.rs2[7:0]} * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_result(input txn_t t);
    logic [31:0] b;
    if (!t.is_load) return 32'd0;
    if (t.word) return t.rdata;
    b = (t.rdata >> (8 * (t.addr % 4))) & 32'hFF;
    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
  endfunction

  function automatic txn_t mk(input logic ld, input logic wd, input logic [31:0] a,
                              input logic [31:0] r2, input logic [31:0] rdv,
                              input logic [4:0] rd, input logic we);
    txn_t t;
    t.is_load = ld; t.word = wd; t.addr = a; t.rs2 = r2; t.rdata = rdv;
    t.rd = rd; t.wr_en = we; t.pc = $urandom;
    return t;
  endfunction

  // ---------------- memory responder ----------------
  int   gnt_fixed   = 0;
  int   rv_fixed    = 0;
  bit   stray_en    = 1'b0;
  int   stray_force = 0;
  int   phase = 0, gwait = 0, rwait = 0;
  txn_t rt;

  initial begin
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    end else begin
      if (phase == 3) phase = 0;
      if (phase == 2) begin
        dmem_gnt = ($urandom_range(0, 1) == 1);  // late grants must be ignored
        if (rwait == 0) begin
          dmem_rvalid = 1'b1;
          if (rsp_q.size() > 0) begin
            rt = rsp_q.pop_front();
            dmem_rdata = rt.rdata;
          end else chk("rsp_underflow", 32'd1, 32'd0);
          rv_cyc_q.push_back(cyc);
          phase = 3;
        end else begin
          dmem_rvalid = 1'b0;
          rwait--;
        end
      end else begin
        dmem_rvalid = (stray_force > 0) || (stray_en && $urandom_range(0, 3) == 0);
        if (stray_force > 0) stray_force--;
        dmem_rdata = $urandom;
        if (phase == 0) begin
          dmem_gnt = 1'b0;
          if (dmem_req) begin
            gwait = (gnt_fixed >= 0) ? gnt_fixed : int'($urandom_range(0, 3));
            phase = 1;
          end
        end
        if (phase == 1) begin
          if (gwait == 0) begin
            dmem_gnt = 1'b1;
            rwait = (rv_fixed >= 0) ? rv_fixed : int'($urandom_range(0, 3));
            phase = 2;
          end else begin
            dmem_gnt = 1'b0;
            gwait--;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  txn_t ct;
  int   rvc;
  bit   prev_wb = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dmem_req) begin
        if (exp_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else begin
          ct = exp_q[0];
          chk("req_addr", dmem_addr, m_addr(ct));
          chk("req_we", {31'd0, dmem_we}, {31'd0, !ct.is_load});
          chk("req_be", {28'd0, dmem_be}, {28'd0, m_be(ct)});
          chk("req_wdata", dmem_wdata, m_wdata(ct));
          chk("req_stall", {31'd0, mem_stall}, 32'd1);
        end
      end
      if (wb_valid) begin
        chk("wb_pulse_width", {31'd0, prev_wb}, 32'd0);
        chk("wb_no_stall", {31'd0, mem_stall}, 32'd0);
        wb_hist.push_back(cyc);
        if (exp_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          ct = exp_q.pop_front();
          chk("wb_reg_wr_en", {31'd0, wb_reg_wr_en}, {31'd0, ct.is_load && ct.wr_en});
          if (ct.is_load) chk("wb_wr_reg", {27'd0, wb_wr_reg}, {27'd0, ct.rd});
          chk("wb_data", wb_data, m_result(ct));
          chk("wb_misaligned", {31'd0, misaligned}, {31'd0, ct.word && (ct.addr % 4 != 0)});
`ifndef SYNTHESIS
          chk("wb_debug_pc", debug_wb_pc, ct.pc);
`endif
        end
        if (rv_cyc_q.size() == 0) chk("wb_without_rvalid", 32'd1, 32'd0);
        else begin
          rvc = rv_cyc_q.pop_front();
          chk("wb_latency", cyc, rvc + 1);
        end
      end else begin
        chk("misaligned_idle", {31'd0, misaligned}, 32'd0);
      end
      prev_wb = wb_valid;
    end else begin
      prev_wb = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input txn_t t, output int acc);
    mem_valid = 1'b1; mem_is_load = t.is_load; mem_is_store = !t.is_load;
    mem_reg_wr_en = t.wr_en; mem_access_size = t.word ? WORD : BYTE;
    mem_alu_result = t.addr; mem_rs2_data = t.rs2; mem_wr_reg = t.rd; debug_pc = t.pc;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      if (!mem_stall) begin
        acc = cyc;
        exp_q.push_back(t);
        rsp_q.push_back(t);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  int          w_cyc, st_n, st_first, rq_n;
  logic [31:0] w_data, rq_addr, rq_wdata;
  logic [4:0]  w_reg;
  logic        w_en, w_mis, rq_we;
  logic [3:0]  rq_be;

  task automatic wait_wb();
    bit seen = 1'b0;
    st_n = 0; st_first = -1; rq_n = 0; w_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (mem_stall) begin st_n++; if (st_first < 0) st_first = cyc; end
      if (dmem_req) begin
        if (rq_n == 0) begin
          rq_addr = dmem_addr; rq_be = dmem_be; rq_wdata = dmem_wdata; rq_we = dmem_we;
        end
        rq_n++;
      end
      if (wb_valid) begin
        seen = 1'b1; w_cyc = cyc; w_data = wb_data; w_reg = wb_wr_reg;
        w_en = wb_reg_wr_en; w_mis = misaligned;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("wb_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int   a, a2;
  bit   seen_wb;
  txn_t t;

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
    mem_reg_wr_en = 1'b0; mem_access_size = BYTE; mem_alu_result = '0;
    mem_rs2_data = '0; mem_wr_reg = '0; debug_pc = '0;
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_reg", {27'd0, wb_wr_reg}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // LW 0x100, immediate grant and response
    gnt_fixed = 0; rv_fixed = 0;
    issue(mk(1, 1, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd5, 1), a);
    wait_wb();
    chk("lw_latency", w_cyc, a + 3);
    chk("lw_data", w_data, 32'hDEAD_BEEF);
    chk("lw_rd", {27'd0, w_reg}, 32'd5);
    chk("lw_stall_cycles", st_n, 32'd2);
    chk("lw_stall_first", st_first, a + 1);

    // LB 0x103: negative byte from lane 3
    issue(mk(1, 0, 32'h103, 32'h0, 32'h80FF_0000, 5'd6, 1), a);
    wait_wb();
    chk("lb3_addr", rq_addr, 32'h100);
    chk("lb3_data", w_data, 32'hFFFF_FF80);

    // LB 0x101: positive byte from lane 1
    issue(mk(1, 0, 32'h101, 32'h0, 32'h0000_7F00, 5'd7, 1), a);
    wait_wb();
    chk("lb1_data", w_data, 32'h0000_007F);

    // SB 0x202
    issue(mk(0, 0, 32'h202, 32'h1234_5678, 32'h0, 5'd8, 1), a);
    wait_wb();
    chk("sb_be", {28'd0, rq_be}, 32'h4);
    chk("sb_wdata", rq_wdata, 32'h7878_7878);
    chk("sb_we", {31'd0, rq_we}, 32'd1);
    chk("sb_wr_en", {31'd0, w_en}, 32'd0);

    // Grant withheld 3 cycles, response delayed 2
    gnt_fixed = 3; rv_fixed = 2;
    issue(mk(1, 1, 32'h340, 32'h0, 32'hA5A5_0001, 5'd9, 1), a);
    wait_wb();
    chk("slow_latency", w_cyc, a + 8);
    chk("slow_req_cycles", rq_n, 32'd4);

    // Reset while waiting for the response, then a stray response
    gnt_fixed = 0; rv_fixed = 3;
    issue(mk(1, 1, 32'h500, 32'h0, 32'h1111_2222, 5'd10, 1), a);
    @(negedge clk);
    chk("rst_wait_stalled", {31'd0, mem_stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_async_wb_data", wb_data, 32'd0);
    chk("rst_async_wb_reg", {27'd0, wb_wr_reg}, 32'd0);
    chk("rst_async_wb_en", {31'd0, wb_reg_wr_en}, 32'd0);
    @(negedge clk);
    exp_q.delete(); rsp_q.delete(); rv_cyc_q.delete();
    stray_force = 3;
    #2 rst_n = 1'b1;
    seen_wb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_valid || dmem_req) seen_wb = 1'b1;
    end
    chk("rst_no_wb", {31'd0, seen_wb}, 32'd0);
    rv_fixed = 0;
    issue(mk(1, 1, 32'h40, 32'h0, 32'h0BAD_F00D, 5'd11, 1), a);
    wait_wb();
    chk("post_rst_latency", w_cyc, a + 3);
    chk("post_rst_data", w_data, 32'h0BAD_F00D);

    // Misaligned word load
    issue(mk(1, 1, 32'h102, 32'h0, 32'h1122_3344, 5'd12, 1), a);
    wait_wb();
    chk("mis_flag", {31'd0, w_mis}, 32'd1);
    chk("mis_addr", rq_addr, 32'h100);

    // Back-to-back word loads
    wb_hist.delete();
    issue(mk(1, 1, 32'h600, 32'h0, 32'hCAFE_0001, 5'd13, 1), a);
    issue(mk(1, 1, 32'h604, 32'h0, 32'hCAFE_0002, 5'd14, 1), a2);
    chk("b2b_accept", a2, a + 3);
    for (int i = 0; i < 40 && wb_hist.size() < 2; i++) @(negedge clk);
    if (wb_hist.size() < 2) chk("b2b_timeout", wb_hist.size(), 32'd2);
    else begin
      chk("b2b_first", wb_hist[0], a + 3);
      chk("b2b_spacing", wb_hist[1] - wb_hist[0], 32'd3);
    end
    drain();

    // Randomized traffic
    gnt_fixed = -1; rv_fixed = -1; stray_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      t = mk(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), $urandom,
             $urandom, $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1));
      issue(t, a);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
